mem_stage: RTL and testbench

Pipeline MEM stage sitting directly upstream of the write-back stage. It accepts one instruction per handshake from EXE and waits for the data-SRAM response when EXE issued a load or store request. It extracts and merges load data (LB/LBU/LH/LHU/LW/LWL/LWR), carries the exception status through, and hands the instruction to WB. It provides forwarding and stall information to decode. On a WB flush it discards the in-flight instruction and drops any data response still owed to a cancelled request.

---
 rtl/mem_stage.sv | 164 ++++++++++++++++
 tb/tb_mem_stage.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for the data-SRAM response, extracts and merges load data,
// and hands the instruction to WB. Flushed requests have their late responses discarded.
module mem_stage #(
  parameter int DISCARD_CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        es_to_ms_valid,
  output logic        ms_allowin,
  input  logic [31:0] es_pc,
  input  logic [2:0]  es_ld_op,
  input  logic [31:0] es_addr,
  input  logic [31:0] es_rt_value,
  input  logic [31:0] es_result,
  input  logic [3:0]  es_gr_we,
  input  logic [4:0]  es_dest,
  input  logic        es_req_sent,
  input  logic        es_ex,
  input  logic [4:0]  es_excode,
  input  logic        ws_allowin,
  input  logic        ws_reflush,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        ms_to_ws_valid,
  output logic [31:0] ms_pc,
  output logic [31:0] ms_final_result,
  output logic [3:0]  ms_gr_we,
  output logic [4:0]  ms_dest,
  output logic        ms_ex,
  output logic [4:0]  ms_excode,
  output logic [31:0] ms_badvaddr,
  output logic        ms_ex_block,
  output logic        ms_fwd_valid,
  output logic        ms_fwd_stall,
  output logic [31:0] ms_fwd_data
);

  localparam logic [DISCARD_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [DISCARD_CNT_W-1:0] CNT_ONE = 1;

  logic                     ms_valid;
  logic                     buf_valid;
  logic [31:0]              buf_data;
  logic [DISCARD_CNT_W-1:0] discard_cnt;
  logic [2:0]               ld_op;
  logic [31:0]              rt_value;
  logic [31:0]              alu_result;
  logic                     req_sent;

  logic        resp_live;
  logic        wait_data;
  logic        ms_ready_go;
  logic        handoff;
  logic        cnt_inc;
  logic        cnt_dec;
  logic [31:0] ld_data;
  logic [1:0]  off;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign resp_live      = data_sram_data_ok && (discard_cnt == '0);
  assign wait_data      = ms_valid && req_sent && !ms_ex && !buf_valid;
  assign ms_ready_go    = !wait_data || resp_live;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go && !ws_reflush;
  assign handoff        = ms_ready_go && ws_allowin;

  // A flushed request whose response has not yet arrived leaves one response owed.
  assign cnt_inc = ws_reflush && ms_valid && req_sent && !buf_valid && !resp_live;
  assign cnt_dec = data_sram_data_ok && (discard_cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid    <= 1'b0;
      buf_valid   <= 1'b0;
      discard_cnt <= '0;
    end else begin
      if (ws_reflush) begin
        ms_valid <= 1'b0;
      end else if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
      end

      if (ws_reflush || handoff) begin
        buf_valid <= 1'b0;
      end else if (resp_live && wait_data && !ws_allowin) begin
        buf_valid <= 1'b1;
      end

      if (cnt_inc && !cnt_dec && discard_cnt != CNT_MAX) begin
        discard_cnt <= discard_cnt + CNT_ONE;
      end else if (cnt_dec && !cnt_inc) begin
        discard_cnt <= discard_cnt - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resp_live && wait_data && !ws_allowin) begin
      buf_data <= data_sram_rdata;
    end
    if (es_to_ms_valid && ms_allowin) begin
      ms_pc       <= es_pc;
      ld_op       <= es_ld_op;
      ms_badvaddr <= es_addr;
      rt_value    <= es_rt_value;
      alu_result  <= es_result;
      ms_gr_we    <= es_gr_we;
      ms_dest     <= es_dest;
      req_sent    <= es_req_sent;
      ms_ex       <= es_ex;
      ms_excode   <= es_excode;
    end
  end

  assign ld_data  = buf_valid ? buf_data : data_sram_rdata;
  assign off      = ms_badvaddr[1:0];
  assign half_val = off[1] ? ld_data[31:16] : ld_data[15:0];

  always_comb begin
    byte_val = ld_data[7:0];
    case (off)
      2'd1:    byte_val = ld_data[15:8];
      2'd2:    byte_val = ld_data[23:16];
      2'd3:    byte_val = ld_data[31:24];
      default: byte_val = ld_data[7:0];
    endcase
  end

  // LWL/LWR merge the loaded bytes with the old rt value around the unaligned address.
  always_comb begin
    ms_final_result = alu_result;
    case (ld_op)
      3'd0: ms_final_result = ld_data;
      3'd1: ms_final_result = {{24{byte_val[7]}}, byte_val};
      3'd2: ms_final_result = {24'h0, byte_val};
      3'd3: ms_final_result = {{16{half_val[15]}}, half_val};
      3'd4: ms_final_result = {16'h0, half_val};
      3'd5: begin
        case (off)
          2'd0:    ms_final_result = {ld_data[7:0],  rt_value[23:0]};
          2'd1:    ms_final_result = {ld_data[15:0], rt_value[15:0]};
          2'd2:    ms_final_result = {ld_data[23:0], rt_value[7:0]};
          default: ms_final_result = ld_data;
        endcase
      end
      3'd6: begin
        case (off)
          2'd0:    ms_final_result = ld_data;
          2'd1:    ms_final_result = {rt_value[31:24], ld_data[31:8]};
          2'd2:    ms_final_result = {rt_value[31:16], ld_data[31:16]};
          default: ms_final_result = {rt_value[31:8],  ld_data[31:24]};
        endcase
      end
      default: ms_final_result = alu_result;
    endcase
  end

  assign ms_ex_block  = ms_valid && ms_ex;
  assign ms_fwd_valid = ms_valid && (|ms_gr_we);
  assign ms_fwd_stall = ms_valid && (ld_op != 3'd7) && !ms_ready_go;
  assign ms_fwd_data  = ms_final_result;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: load extraction, response waiting,
// buffering under WB back-pressure, flush discard and exception pass-through.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc;
  logic [2:0]  es_ld_op;
  logic [31:0] es_addr;
  logic [31:0] es_rt_value;
  logic [31:0] es_result;
  logic [3:0]  es_gr_we;
  logic [4:0]  es_dest;
  logic        es_req_sent;
  logic        es_ex;
  logic [4:0]  es_excode;
  logic        ws_allowin;
  logic        ws_reflush;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic [31:0] ms_final_result;
  logic [3:0]  ms_gr_we;
  logic [4:0]  ms_dest;
  logic        ms_ex;
  logic [4:0]  ms_excode;
  logic [31:0] ms_badvaddr;
  logic        ms_ex_block;
  logic        ms_fwd_valid;
  logic        ms_fwd_stall;
  logic [31:0] ms_fwd_data;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] rt;
    logic [31:0] rdata;
    logic [31:0] expected;
  } vec_t;

  vec_t vecs[18];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .es_to_ms_valid    (es_to_ms_valid),
    .ms_allowin        (ms_allowin),
    .es_pc             (es_pc),
    .es_ld_op          (es_ld_op),
    .es_addr           (es_addr),
    .es_rt_value       (es_rt_value),
    .es_result         (es_result),
    .es_gr_we          (es_gr_we),
    .es_dest           (es_dest),
    .es_req_sent       (es_req_sent),
    .es_ex             (es_ex),
    .es_excode         (es_excode),
    .ws_allowin        (ws_allowin),
    .ws_reflush        (ws_reflush),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_pc             (ms_pc),
    .ms_final_result   (ms_final_result),
    .ms_gr_we          (ms_gr_we),
    .ms_dest           (ms_dest),
    .ms_ex             (ms_ex),
    .ms_excode         (ms_excode),
    .ms_badvaddr       (ms_badvaddr),
    .ms_ex_block       (ms_ex_block),
    .ms_fwd_valid      (ms_fwd_valid),
    .ms_fwd_stall      (ms_fwd_stall),
    .ms_fwd_data       (ms_fwd_data)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction from EXE for a single cycle; it sits in MEM afterwards.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rt,
                               input logic [31:0] result, input logic req, input logic ex,
                               input logic [4:0] code, input logic [3:0] we);
    es_to_ms_valid = 1'b1;
    es_ld_op       = op;
    es_addr        = addr;
    es_rt_value    = rt;
    es_result      = result;
    es_req_sent    = req;
    es_ex          = ex;
    es_excode      = code;
    es_gr_we       = we;
    @(negedge clk);
    checkOutput("allowin_entry", 32'(ms_allowin), 32'd1);
    nextCycle();
    es_to_ms_valid = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    es_to_ms_valid    = 1'b0;
    es_pc             = 32'h0;
    es_ld_op          = 3'd7;
    es_addr           = 32'h0;
    es_rt_value       = 32'h0;
    es_result         = 32'h0;
    es_gr_we          = 4'h0;
    es_dest           = 5'd0;
    es_req_sent       = 1'b0;
    es_ex             = 1'b0;
    es_excode         = 5'd0;
    ws_allowin        = 1'b1;
    ws_reflush        = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;

    vecs[0]  = '{3'd0, 32'h0000_2000, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344};
    vecs[1]  = '{3'd1, 32'h0000_2000, 32'hAABB_CCDD, 32'h1122_3344, 32'h0000_0044};
    vecs[2]  = '{3'd1, 32'h0000_2002, 32'hAABB_CCDD, 32'h11A2_3344, 32'hFFFF_FFA2};
    vecs[3]  = '{3'd2, 32'h0000_2002, 32'hAABB_CCDD, 32'h11A2_3344, 32'h0000_00A2};
    vecs[4]  = '{3'd3, 32'h0000_2000, 32'hAABB_CCDD, 32'h1122_B344, 32'hFFFF_B344};
    vecs[5]  = '{3'd4, 32'h0000_2000, 32'hAABB_CCDD, 32'h1122_B344, 32'h0000_B344};
    vecs[6]  = '{3'd3, 32'h0000_2002, 32'hAABB_CCDD, 32'h80FF_1234, 32'hFFFF_80FF};
    vecs[7]  = '{3'd5, 32'h0000_2000, 32'hAABB_CCDD, 32'h1122_3344, 32'h44BB_CCDD};
    vecs[8]  = '{3'd5, 32'h0000_2001, 32'hAABB_CCDD, 32'h1122_3344, 32'h3344_CCDD};
    vecs[9]  = '{3'd5, 32'h0000_2002, 32'hAABB_CCDD, 32'h1122_3344, 32'h2233_44DD};
    vecs[10] = '{3'd5, 32'h0000_2003, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344};
    vecs[11] = '{3'd6, 32'h0000_2000, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344};
    vecs[12] = '{3'd6, 32'h0000_2001, 32'hAABB_CCDD, 32'h1122_3344, 32'hAA11_2233};
    vecs[13] = '{3'd6, 32'h0000_2002, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_1122};
    vecs[14] = '{3'd6, 32'h0000_2003, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CC11};
    vecs[15] = '{3'd7, 32'h0000_2000, 32'hAABB_CCDD, 32'h1122_3344, 32'hDEAD_BEEF};
    vecs[16] = '{3'd4, 32'h0000_2002, 32'hAABB_CCDD, 32'h80FF_1234, 32'h0000_80FF};
    vecs[17] = '{3'd2, 32'h0000_2001, 32'hAABB_CCDD, 32'h80FF_1234, 32'h0000_0012};

    nextCycle();
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_to_ws_valid", 32'(ms_to_ws_valid), 32'd0);
    checkOutput("rst_allowin", 32'(ms_allowin), 32'd1);
    checkOutput("rst_fwd_valid", 32'(ms_fwd_valid), 32'd0);
    checkOutput("rst_fwd_stall", 32'(ms_fwd_stall), 32'd0);
    checkOutput("rst_ex_block", 32'(ms_ex_block), 32'd0);
    nextCycle();

    // LB at offset 3 with the response two cycles after entry
    es_pc   = 32'hBFC0_0040;
    es_dest = 5'd9;
    applyStimulus(3'd1, 32'h0000_1003, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 4'hF);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput($sformatf("lb_stall_c%0d", c), 32'(ms_fwd_stall), 32'd1);
      checkOutput($sformatf("lb_to_ws_c%0d", c), 32'(ms_to_ws_valid), 32'd0);
      checkOutput($sformatf("lb_allowin_c%0d", c), 32'(ms_allowin), 32'd0);
      nextCycle();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF_1234;
    @(negedge clk);
    checkOutput("lb_stall_done", 32'(ms_fwd_stall), 32'd0);
    checkOutput("lb_to_ws", 32'(ms_to_ws_valid), 32'd1);
    checkOutput("lb_result", ms_final_result, 32'hFFFF_FF80);
    checkOutput("lb_fwd_data", ms_fwd_data, 32'hFFFF_FF80);
    checkOutput("lb_fwd_valid", 32'(ms_fwd_valid), 32'd1);
    checkOutput("lb_pc", ms_pc, 32'hBFC0_0040);
    checkOutput("lb_dest", 32'(ms_dest), 32'd9);
    checkOutput("lb_gr_we", 32'(ms_gr_we), 32'hF);
    nextCycle();
    data_sram_data_ok = 1'b0;

    // Zero-wait loads and one ALU pass-through
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].rt,
                    (vecs[i].op == 3'd7) ? vecs[i].expected : 32'h0BAD_0000,
                    vecs[i].op != 3'd7, 1'b0, 5'd0, 4'hF);
      if (vecs[i].op != 3'd7) begin
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = vecs[i].rdata;
      end
      @(negedge clk);
      checkOutput($sformatf("vec%0d_to_ws", i), 32'(ms_to_ws_valid), 32'd1);
      checkOutput($sformatf("vec%0d_result", i), ms_final_result, vecs[i].expected);
      nextCycle();
      data_sram_data_ok = 1'b0;
    end

    // Response arrives while WB is blocked; the buffered value must survive rdata changes
    applyStimulus(3'd0, 32'h0000_3000, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 4'hF);
    ws_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hCAFE_F00D;
    @(negedge clk);
    checkOutput("buf_first_allowin", 32'(ms_allowin), 32'd0);
    nextCycle();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h1234_5678;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput($sformatf("buf_hold_c%0d_to_ws", c), 32'(ms_to_ws_valid), 32'd1);
      checkOutput($sformatf("buf_hold_c%0d_result", c), ms_final_result, 32'hCAFE_F00D);
      checkOutput($sformatf("buf_hold_c%0d_allowin", c), 32'(ms_allowin), 32'd0);
      checkOutput($sformatf("buf_hold_c%0d_stall", c), 32'(ms_fwd_stall), 32'd0);
      nextCycle();
    end
    ws_allowin = 1'b1;
    @(negedge clk);
    checkOutput("buf_release_allowin", 32'(ms_allowin), 32'd1);
    checkOutput("buf_release_result", ms_final_result, 32'hCAFE_F00D);
    nextCycle();

    // Flush while a load still waits: the next load must drop one response
    applyStimulus(3'd0, 32'h0000_4000, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 4'hF);
    ws_reflush = 1'b1;
    @(negedge clk);
    checkOutput("flush_wait_stall", 32'(ms_fwd_stall), 32'd1);
    checkOutput("flush_wait_to_ws", 32'(ms_to_ws_valid), 32'd0);
    nextCycle();
    ws_reflush = 1'b0;
    @(negedge clk);
    checkOutput("flush_after_allowin", 32'(ms_allowin), 32'd1);
    checkOutput("flush_after_to_ws", 32'(ms_to_ws_valid), 32'd0);
    nextCycle();
    applyStimulus(3'd0, 32'h0000_4004, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 4'hF);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hBAD0_BAD0;
    @(negedge clk);
    checkOutput("discard_to_ws", 32'(ms_to_ws_valid), 32'd0);
    checkOutput("discard_stall", 32'(ms_fwd_stall), 32'd1);
    nextCycle();
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    checkOutput("discard_gap_stall", 32'(ms_fwd_stall), 32'd1);
    nextCycle();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h600D_600D;
    @(negedge clk);
    checkOutput("discard_done_to_ws", 32'(ms_to_ws_valid), 32'd1);
    checkOutput("discard_done_result", ms_final_result, 32'h600D_600D);
    nextCycle();
    data_sram_data_ok = 1'b0;

    // Flush in the same cycle as the response: nothing is owed afterwards
    applyStimulus(3'd0, 32'h0000_5000, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 4'hF);
    ws_reflush        = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h5555_AAAA;
    @(negedge clk);
    checkOutput("flush_ok_to_ws", 32'(ms_to_ws_valid), 32'd0);
    nextCycle();
    ws_reflush        = 1'b0;
    data_sram_data_ok = 1'b0;
    applyStimulus(3'd0, 32'h0000_5004, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 4'hF);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h7777_8888;
    @(negedge clk);
    checkOutput("flush_ok_next_to_ws", 32'(ms_to_ws_valid), 32'd1);
    checkOutput("flush_ok_next_result", ms_final_result, 32'h7777_8888);
    nextCycle();
    data_sram_data_ok = 1'b0;

    // Exception passes through in one cycle with no request outstanding
    es_pc = 32'hBFC0_0100;
    applyStimulus(3'd0, 32'h0000_5003, 32'h0, 32'h0, 1'b0, 1'b1, 5'd4, 4'h0);
    @(negedge clk);
    checkOutput("ex_to_ws", 32'(ms_to_ws_valid), 32'd1);
    checkOutput("ex_flag", 32'(ms_ex), 32'd1);
    checkOutput("ex_code", 32'(ms_excode), 32'd4);
    checkOutput("ex_badvaddr", ms_badvaddr, 32'h0000_5003);
    checkOutput("ex_block", 32'(ms_ex_block), 32'd1);
    checkOutput("ex_fwd_valid", 32'(ms_fwd_valid), 32'd0);
    checkOutput("ex_stall", 32'(ms_fwd_stall), 32'd0);
    checkOutput("ex_pc", ms_pc, 32'hBFC0_0100);
    nextCycle();

    // Reset while a load waits clears the stage
    applyStimulus(3'd0, 32'h0000_6000, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 4'hF);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_to_ws", 32'(ms_to_ws_valid), 32'd0);
    checkOutput("midrst_allowin", 32'(ms_allowin), 32'd1);
    checkOutput("midrst_stall", 32'(ms_fwd_stall), 32'd0);
    nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
